// File: rtl/uart_pkg.sv
// Shared UART constants and a small elaboration-time helper.
package uart_pkg;

   localparam int UART_WIDTH       = 8;
   localparam int RX_FIFO_DEPTH    = 16;
   localparam int RX_FIFO_AF_LEVEL = 12;

   // Smallest r such that 2**r >= value (value >= 1).
   function automatic int log2_ceil(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port RAM: synchronous write, synchronous registered read.
// The read register is reset so the FIFO data output starts at zero and holds
// its value until the next read enable; the array itself is never cleared.
module uart_fifo_mem
   import uart_pkg::*;
#(
   parameter int WIDTH = UART_WIDTH,
   parameter int DEPTH = RX_FIFO_DEPTH
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          we,
   input  logic [log2_ceil(DEPTH)-1:0]   waddr,
   input  logic [WIDTH-1:0]              wdata,
   input  logic                          re,
   input  logic [log2_ceil(DEPTH)-1:0]   raddr,
   output logic [WIDTH-1:0]              rdata
);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [WIDTH-1:0] rdata_r;

   // Storage array write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   // Registered read port; old data is returned on a same-address write.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_r <= {WIDTH{1'b0}};
      end else if (re) begin
         rdata_r <= mem_r[raddr];
      end
   end

   assign rdata = rdata_r;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO between the UART RX FSM and the host read port.
// Pointer/counter control with level, almost-full and sticky error status.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int WIDTH    = UART_WIDTH,
   parameter int DEPTH    = RX_FIFO_DEPTH,
   parameter int AF_LEVEL = RX_FIFO_AF_LEVEL
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        fifo_we_i,
   input  logic [WIDTH-1:0]            din,
   input  logic                        rd_en,
   input  logic                        clr_err,
   output logic [WIDTH-1:0]            dout,
   output logic                        dout_valid,
   output logic                        empty,
   output logic                        full,
   output logic                        almost_full,
   output logic [log2_ceil(DEPTH):0]   count,
   output logic                        overflow,
   output logic                        underflow
);

   localparam int PTR_W = log2_ceil(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic [CNT_W-1:0] count_nxt_s;
   logic             dout_valid_r;
   logic             overflow_r;
   logic             underflow_r;
   logic             overflow_nxt_s;
   logic             underflow_nxt_s;
   logic             empty_s;
   logic             full_s;
   logic             wa_s;
   logic             ra_s;

   assign empty_s = (count_r == {CNT_W{1'b0}});
   assign full_s  = (count_r == CNT_W'(DEPTH));

   // A full FIFO still takes a write when a read frees a slot in the same cycle.
   assign ra_s = rd_en & ~empty_s;
   assign wa_s = fifo_we_i & (~full_s | ra_s);

   uart_fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .rst   (rst),
      .we    (wa_s),
      .waddr (wr_ptr_r),
      .wdata (din),
      .re    (ra_s),
      .raddr (rd_ptr_r),
      .rdata (dout)
   );

   // Next occupancy from accepted write/read.
   always_comb begin
      count_nxt_s = count_r;
      case ({wa_s, ra_s})
         2'b10:   count_nxt_s = count_r + CNT_W'(1);
         2'b01:   count_nxt_s = count_r - CNT_W'(1);
         default: count_nxt_s = count_r;
      endcase
   end

   // Sticky error flags: a new event wins over a clear in the same cycle.
   always_comb begin
      overflow_nxt_s  = overflow_r;
      underflow_nxt_s = underflow_r;
      if (fifo_we_i && full_s && !ra_s) begin
         overflow_nxt_s = 1'b1;
      end else if (clr_err) begin
         overflow_nxt_s = 1'b0;
      end else begin
         overflow_nxt_s = overflow_r;
      end
      if (rd_en && empty_s) begin
         underflow_nxt_s = 1'b1;
      end else if (clr_err) begin
         underflow_nxt_s = 1'b0;
      end else begin
         underflow_nxt_s = underflow_r;
      end
   end

   // Pointer, count, read-valid pulse and flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r     <= {PTR_W{1'b0}};
         rd_ptr_r     <= {PTR_W{1'b0}};
         count_r      <= {CNT_W{1'b0}};
         dout_valid_r <= 1'b0;
         overflow_r   <= 1'b0;
         underflow_r  <= 1'b0;
      end else begin
         if (wa_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (ra_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         count_r      <= count_nxt_s;
         dout_valid_r <= ra_s;
         overflow_r   <= overflow_nxt_s;
         underflow_r  <= underflow_nxt_s;
      end
   end

   assign count       = count_r;
   assign empty       = empty_s;
   assign full        = full_s;
   assign almost_full = (count_r >= CNT_W'(AF_LEVEL));
   assign dout_valid  = dout_valid_r;
   assign overflow    = overflow_r;
   assign underflow   = underflow_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (WIDTH=8, DEPTH=16, AF_LEVEL=12).
module tb_uart_rx_fifo;

   logic       clk;
   logic       rst;
   logic       fifo_we_i;
   logic [7:0] din;
   logic       rd_en;
   logic       clr_err;
   logic [7:0] dout;
   logic       dout_valid;
   logic       empty;
   logic       full;
   logic       almost_full;
   logic [4:0] count;
   logic       overflow;
   logic       underflow;

   int checks = 0;
   int errors = 0;

   uart_rx_fifo #(
      .WIDTH    (8),
      .DEPTH    (16),
      .AF_LEVEL (12)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .fifo_we_i   (fifo_we_i),
      .din         (din),
      .rd_en       (rd_en),
      .clr_err     (clr_err),
      .dout        (dout),
      .dout_valid  (dout_valid),
      .empty       (empty),
      .full        (full),
      .almost_full (almost_full),
      .count       (count),
      .overflow    (overflow),
      .underflow   (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One rising edge; outputs are sampled 1ns later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; fifo_we_i = 1'b0; rd_en = 1'b0; clr_err = 1'b0; din = 8'h00;
      step();
      rst = 1'b0;
   endtask

   task automatic push(input logic [7:0] b);
      fifo_we_i = 1'b1; din = b;
      step();
      fifo_we_i = 1'b0;
   endtask

   task automatic pop();
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
      checks++; if ({empty, full, almost_full} !== 3'b100) begin errors++; $display("FAIL reset_flags got %b exp 100", {empty, full, almost_full}); end
      checks++; if ({dout_valid, overflow, underflow} !== 3'b000) begin errors++; $display("FAIL reset_status got %b exp 000", {dout_valid, overflow, underflow}); end
      checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h exp 00", dout); end
   endtask

   task automatic test_basic();
      logic [7:0] vals [3];
      vals[0] = 8'hA5; vals[1] = 8'h3C; vals[2] = 8'hFF;
      do_reset();
      for (int i = 0; i < 3; i++) push(vals[i]);
      checks++; if (count !== 5'd3) begin errors++; $display("FAIL basic_count3 got %0d exp 3", count); end
      for (int i = 0; i < 3; i++) begin
         pop();
         checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL basic_valid[%0d] got %b exp 1", i, dout_valid); end
         checks++; if (dout !== vals[i]) begin errors++; $display("FAIL basic_dout[%0d] got %h exp %h", i, dout, vals[i]); end
         checks++; if (count !== 5'(2 - i)) begin errors++; $display("FAIL basic_count[%0d] got %0d exp %0d", i, count, 2 - i); end
      end
      step();
      checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_idle got %b exp 0", dout_valid); end
      checks++; if (dout !== 8'hFF) begin errors++; $display("FAIL basic_dout_hold got %h exp ff", dout); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL basic_empty got %b exp 1", empty); end
   endtask

   task automatic test_full_overflow();
      do_reset();
      for (int i = 0; i < 16; i++) begin
         push(8'(i));
         checks++; if (almost_full !== (i + 1 >= 12)) begin errors++; $display("FAIL af_at_%0d got %b exp %b", i + 1, almost_full, (i + 1 >= 12)); end
      end
      checks++; if ({full, count} !== {1'b1, 5'd16}) begin errors++; $display("FAIL full_count got %b/%0d exp 1/16", full, count); end
      push(8'h10);
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_set got %b exp 1", overflow); end
      checks++; if (count !== 5'd16) begin errors++; $display("FAIL overflow_count got %0d exp 16", count); end
      for (int i = 0; i < 16; i++) begin
         pop();
         checks++; if ({dout_valid, dout} !== {1'b1, 8'(i)}) begin errors++; $display("FAIL drain[%0d] got %b/%h exp 1/%h", i, dout_valid, dout, 8'(i)); end
      end
      checks++; if ({empty, count} !== {1'b1, 5'd0}) begin errors++; $display("FAIL drain_empty got %b/%0d exp 1/0", empty, count); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_sticky got %b exp 1", overflow); end
   endtask

   task automatic test_full_rw();
      do_reset();
      for (int i = 0; i < 16; i++) push(8'(i));
      fifo_we_i = 1'b1; din = 8'h77; rd_en = 1'b1;
      step();
      fifo_we_i = 1'b0; rd_en = 1'b0;
      checks++; if ({dout_valid, dout} !== {1'b1, 8'h00}) begin errors++; $display("FAIL fullrw_dout got %b/%h exp 1/00", dout_valid, dout); end
      checks++; if (count !== 5'd16) begin errors++; $display("FAIL fullrw_count got %0d exp 16", count); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullrw_overflow got %b exp 0", overflow); end
      for (int i = 1; i < 17; i++) begin
         pop();
         checks++; if (dout !== ((i == 16) ? 8'h77 : 8'(i))) begin errors++; $display("FAIL fullrw_drain[%0d] got %h exp %h", i, dout, ((i == 16) ? 8'h77 : 8'(i))); end
      end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fullrw_empty got %b exp 1", empty); end
   endtask

   task automatic test_underflow_clr();
      do_reset();
      fifo_we_i = 1'b1; din = 8'h5A; rd_en = 1'b1;
      step();
      fifo_we_i = 1'b0; rd_en = 1'b0;
      checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL unf_valid got %b exp 0", dout_valid); end
      checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL unf_set got %b exp 1", underflow); end
      checks++; if (count !== 5'd1) begin errors++; $display("FAIL unf_count got %0d exp 1", count); end
      pop();
      checks++; if ({dout_valid, dout} !== {1'b1, 8'h5A}) begin errors++; $display("FAIL unf_read got %b/%h exp 1/5a", dout_valid, dout); end
      for (int i = 0; i < 17; i++) push(8'hC0 + 8'(i));
      checks++; if ({overflow, underflow} !== 2'b11) begin errors++; $display("FAIL both_set got %b exp 11", {overflow, underflow}); end
      // A dropped write in the clearing cycle keeps overflow set.
      clr_err = 1'b1; fifo_we_i = 1'b1; din = 8'hEE;
      step();
      fifo_we_i = 1'b0;
      checks++; if ({overflow, underflow} !== 2'b10) begin errors++; $display("FAIL clr_priority got %b exp 10", {overflow, underflow}); end
      step();
      clr_err = 1'b0;
      checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL clr_both got %b exp 00", {overflow, underflow}); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] q [$];
      logic [7:0] exp_b;
      int         reads;
      do_reset();
      reads = 0;
      for (int k = 0; k < 3; k++) begin
         q.push_back(8'((k * 7 + 3) & 255));
         push(8'((k * 7 + 3) & 255));
      end
      for (int k = 3; k < 40; k++) begin
         exp_b = q.pop_front();
         q.push_back(8'((k * 7 + 3) & 255));
         fifo_we_i = 1'b1; din = 8'((k * 7 + 3) & 255); rd_en = 1'b1;
         step();
         fifo_we_i = 1'b0; rd_en = 1'b0;
         reads++;
         checks++; if ({dout_valid, dout} !== {1'b1, exp_b}) begin errors++; $display("FAIL b2b[%0d] got %b/%h exp 1/%h", reads, dout_valid, dout, exp_b); end
      end
      checks++; if (count !== 5'd3) begin errors++; $display("FAIL b2b_count got %0d exp 3", count); end
      while (q.size() > 0) begin
         exp_b = q.pop_front();
         pop();
         reads++;
         checks++; if ({dout_valid, dout} !== {1'b1, exp_b}) begin errors++; $display("FAIL b2b_tail[%0d] got %b/%h exp 1/%h", reads, dout_valid, dout, exp_b); end
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      pop();
      for (int i = 0; i < 9; i++) push(8'h90 + 8'(i));
      checks++; if ({count, underflow} !== {5'd9, 1'b1}) begin errors++; $display("FAIL mid_pre got %0d/%b exp 9/1", count, underflow); end
      rd_en = 1'b1;
      step();
      checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL mid_valid_pre got %b exp 1", dout_valid); end
      rst = 1'b1; fifo_we_i = 1'b1; din = 8'h11;
      step();
      rst = 1'b0; fifo_we_i = 1'b0; rd_en = 1'b0;
      checks++; if ({count, empty} !== {5'd0, 1'b1}) begin errors++; $display("FAIL mid_count got %0d/%b exp 0/1", count, empty); end
      checks++; if ({dout_valid, overflow, underflow} !== 3'b000) begin errors++; $display("FAIL mid_status got %b exp 000", {dout_valid, overflow, underflow}); end
      checks++; if (dout !== 8'h00) begin errors++; $display("FAIL mid_dout got %h exp 00", dout); end
   endtask

   initial begin
      rst = 1'b1; fifo_we_i = 1'b0; din = 8'h00; rd_en = 1'b0; clr_err = 1'b0;
      test_reset();
      test_basic();
      test_full_overflow();
      test_full_rw();
      test_underflow_clr();
      test_back_to_back();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
